// File: rtl/biquad_pkg.sv
// Shared types and helpers for the time-multiplexed biquad bank.
package biquad_pkg;

   localparam int unsigned NUM_COEF  = 5;
   localparam int unsigned SAT_MAX_W = 128;

   typedef enum logic [2:0] {
      B0 = 3'd0,
      B1 = 3'd1,
      B2 = 3'd2,
      A1 = 3'd3,
      A2 = 3'd4
   } coef_idx_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MAC    = 2'd1,
      UPDATE = 2'd2,
      OUT    = 2'd3
   } state_e;

   // Clamp a wide signed value to the signed range of a w-bit word (w < SAT_MAX_W).
   function automatic logic signed [SAT_MAX_W-1:0] sat_to_width(
      input logic signed [SAT_MAX_W-1:0] v,
      input int unsigned                 w
   );
      logic signed [SAT_MAX_W-1:0] lim;
      lim = SAT_MAX_W'(1) << (w - 1);
      if (v > (lim - SAT_MAX_W'(1))) begin
         return lim - SAT_MAX_W'(1);
      end
      if (v < -lim) begin
         return -lim;
      end
      return v;
   endfunction

endpackage

// File: rtl/biquad_mac.sv
// Shared multiply-shift-accumulate unit: acc <= (clr ? 0 : acc) +/- ((coef * operand) >>> SHIFT).
module biquad_mac #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned COEF_W = 32,
   parameter int unsigned SHIFT  = 20,
   parameter int unsigned ACC_W  = 64
) (
   input  logic                     clk_in,
   input  logic                     rst_n_in,
   input  logic                     en,
   input  logic                     clr,
   input  logic                     sub,
   input  logic signed [COEF_W-1:0] coef,
   input  logic signed [DATA_W-1:0] operand,
   output logic signed [ACC_W-1:0]  acc
);

   localparam int unsigned PROD_W = DATA_W + COEF_W;

   logic signed [PROD_W-1:0] prod;
   logic signed [PROD_W-1:0] prod_sh;
   logic signed [ACC_W-1:0]  term;
   logic signed [ACC_W-1:0]  base;

   always_comb begin
      prod    = PROD_W'(coef) * PROD_W'(operand);
      prod_sh = prod >>> SHIFT;
      term    = ACC_W'(prod_sh);
      base    = clr ? '0 : acc;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         acc <= '0;
      end else if (en) begin
         acc <= sub ? (base - term) : (base + term);
      end
   end

endmodule

// File: rtl/biquad_bank.sv
// Multi-channel cascade of Direct Form I biquads sharing one MAC unit.
// Coefficients are shared by all channels; history is kept per (channel, stage).
module biquad_bank
   import biquad_pkg::*;
#(
   parameter int unsigned  DATA_W     = 32,
   parameter int unsigned  COEF_W     = 32,
   parameter int unsigned  SHIFT      = 20,
   parameter int unsigned  ACC_W      = 64,
   parameter int unsigned  NUM_CH     = 2,
   parameter int unsigned  NUM_STAGES = 2,
   localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int unsigned ADDR_W     = $clog2(NUM_COEF * NUM_STAGES)
) (
   input  logic                     clk_in,
   input  logic                     rst_n_in,
   input  logic signed [DATA_W-1:0] sample_in,
   input  logic [CH_W-1:0]          ch_in,
   input  logic                     valid_in,
   output logic                     ready_out,
   output logic signed [DATA_W-1:0] sample_out,
   output logic [CH_W-1:0]          ch_out,
   output logic                     valid_out,
   output logic                     sat_out,
   input  logic                     coef_we_in,
   input  logic [ADDR_W-1:0]        coef_addr_in,
   input  logic signed [COEF_W-1:0] coef_data_in,
   input  logic                     hist_clr_in
);

   localparam int unsigned STG_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
   localparam logic signed [COEF_W-1:0] UNITY = COEF_W'(1) << SHIFT;

   state_e state_q, state_d;

   logic [2:0]               k_q;
   logic [STG_W-1:0]         stage_q;
   logic [CH_W-1:0]          ch_q;
   logic signed [DATA_W-1:0] x_q;
   logic                     sat_q;

   logic signed [DATA_W-1:0] x1_q [NUM_CH][NUM_STAGES];
   logic signed [DATA_W-1:0] x2_q [NUM_CH][NUM_STAGES];
   logic signed [DATA_W-1:0] y1_q [NUM_CH][NUM_STAGES];
   logic signed [DATA_W-1:0] y2_q [NUM_CH][NUM_STAGES];
   logic signed [COEF_W-1:0] coef_q [NUM_STAGES][NUM_COEF];

   logic ready_c, accept_c, hclr_c, cwr_c;
   logic mac_en_c, mac_clr_c, mac_sub_c, upd_c, last_c, ch_ok_c;

   logic signed [DATA_W-1:0]    operand_c;
   logic signed [COEF_W-1:0]    coef_c;
   logic signed [ACC_W-1:0]     acc;
   logic signed [SAT_MAX_W-1:0] acc_wide_c;
   logic signed [SAT_MAX_W-1:0] y_wide_c;
   logic signed [DATA_W-1:0]    y_c;
   logic                        sat_now_c;

   assign ready_out = ready_c;

   // Operand/coefficient selection for the current MAC step.
   always_comb begin
      operand_c = x_q;
      case (k_q)
         3'(B0):  operand_c = x_q;
         3'(B1):  operand_c = x1_q[ch_q][stage_q];
         3'(B2):  operand_c = x2_q[ch_q][stage_q];
         3'(A1):  operand_c = y1_q[ch_q][stage_q];
         3'(A2):  operand_c = y2_q[ch_q][stage_q];
         default: operand_c = x_q;
      endcase
      coef_c    = coef_q[stage_q][k_q];
      mac_sub_c = (k_q == 3'(A1)) || (k_q == 3'(A2));
      last_c    = (stage_q == STG_W'(NUM_STAGES - 1));
      ch_ok_c   = (32'(ch_in) < NUM_CH);
   end

   // Saturate the finished section sum back to sample width.
   always_comb begin
      acc_wide_c = SAT_MAX_W'(acc);
      y_wide_c   = sat_to_width(acc_wide_c, DATA_W);
      y_c        = DATA_W'(y_wide_c);
      sat_now_c  = (y_wide_c != acc_wide_c);
   end

   biquad_mac #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .SHIFT  (SHIFT),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .en       (mac_en_c),
      .clr      (mac_clr_c),
      .sub      (mac_sub_c),
      .coef     (coef_c),
      .operand  (operand_c),
      .acc      (acc)
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and per-cycle control strobes.
   always_comb begin
      state_d   = state_q;
      ready_c   = 1'b0;
      accept_c  = 1'b0;
      hclr_c    = 1'b0;
      cwr_c     = 1'b0;
      mac_en_c  = 1'b0;
      mac_clr_c = 1'b0;
      upd_c     = 1'b0;
      case (state_q)
         IDLE: begin
            ready_c = ~hist_clr_in;
            cwr_c   = coef_we_in;
            if (hist_clr_in) begin
               hclr_c = 1'b1;
            end else if (valid_in && ch_ok_c) begin
               accept_c = 1'b1;
               state_d  = MAC;
            end
         end
         MAC: begin
            mac_en_c  = 1'b1;
            mac_clr_c = (k_q == 3'(B0));
            if (k_q == 3'(A2)) begin
               state_d = UPDATE;
            end
         end
         UPDATE: begin
            upd_c   = 1'b1;
            state_d = last_c ? OUT : MAC;
         end
         OUT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Sample/stage sequencing and registered result outputs.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         k_q        <= '0;
         stage_q    <= '0;
         ch_q       <= '0;
         x_q        <= '0;
         sat_q      <= 1'b0;
         sample_out <= '0;
         ch_out     <= '0;
         valid_out  <= 1'b0;
         sat_out    <= 1'b0;
      end else begin
         valid_out <= 1'b0;
         sat_out   <= 1'b0;
         if (accept_c) begin
            ch_q    <= ch_in;
            x_q     <= sample_in;
            stage_q <= '0;
            k_q     <= '0;
            sat_q   <= 1'b0;
         end
         if (mac_en_c) begin
            k_q <= (k_q == 3'(A2)) ? 3'd0 : (k_q + 3'd1);
         end
         if (upd_c) begin
            x_q   <= y_c;
            sat_q <= sat_q | sat_now_c;
            if (last_c) begin
               valid_out  <= 1'b1;
               sample_out <= y_c;
               ch_out     <= ch_q;
               sat_out    <= sat_q | sat_now_c;
            end else begin
               stage_q <= stage_q + STG_W'(1);
            end
         end
      end
   end

   // Per-channel, per-stage delay lines.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            for (int unsigned s = 0; s < NUM_STAGES; s++) begin
               x1_q[c][s] <= '0;
               x2_q[c][s] <= '0;
               y1_q[c][s] <= '0;
               y2_q[c][s] <= '0;
            end
         end
      end else if (hclr_c) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            for (int unsigned s = 0; s < NUM_STAGES; s++) begin
               x1_q[c][s] <= '0;
               x2_q[c][s] <= '0;
               y1_q[c][s] <= '0;
               y2_q[c][s] <= '0;
            end
         end
      end else if (upd_c) begin
         x2_q[ch_q][stage_q] <= x1_q[ch_q][stage_q];
         x1_q[ch_q][stage_q] <= x_q;
         y2_q[ch_q][stage_q] <= y1_q[ch_q][stage_q];
         y1_q[ch_q][stage_q] <= y_c;
      end
   end

   // Coefficient store; resets to a unity-gain passthrough.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int unsigned s = 0; s < NUM_STAGES; s++) begin
            for (int unsigned k = 0; k < NUM_COEF; k++) begin
               coef_q[s][k] <= '0;
            end
            coef_q[s][0] <= UNITY;
         end
      end else if (cwr_c) begin
         for (int unsigned s = 0; s < NUM_STAGES; s++) begin
            for (int unsigned k = 0; k < NUM_COEF; k++) begin
               if (coef_addr_in == ADDR_W'(s * NUM_COEF + k)) begin
                  coef_q[s][k] <= coef_data_in;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_biquad_bank.sv
// Self-checking bench for biquad_bank: directed vector table, busy/reset/clear
// sequences, randomized samples against a floating-free integer reference model.
module tb_biquad_bank;

   localparam int unsigned NUM_STAGES = 2;
   localparam int          SHIFT      = 20;
   localparam longint      MAXV       = 64'sd2147483647;
   localparam longint      MINV       = -64'sd2147483648;

   logic clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   logic               rst_n_in;
   logic signed [31:0] sample_in;
   logic [0:0]         ch_in;
   logic               valid_in;
   logic               ready_out;
   logic signed [31:0] sample_out;
   logic [0:0]         ch_out;
   logic               valid_out;
   logic               sat_out;
   logic               coef_we_in;
   logic [3:0]         coef_addr_in;
   logic signed [31:0] coef_data_in;
   logic               hist_clr_in;

   logic signed [31:0] d3_sample;
   logic [1:0]         d3_ch;
   logic               d3_valid;
   logic               d3_ready;
   logic signed [31:0] d3_sample_out;
   logic [1:0]         d3_ch_out;
   logic               d3_valid_out;
   logic               d3_sat_out;

   biquad_bank u_dut (
      .clk_in       (clk_in),
      .rst_n_in     (rst_n_in),
      .sample_in    (sample_in),
      .ch_in        (ch_in),
      .valid_in     (valid_in),
      .ready_out    (ready_out),
      .sample_out   (sample_out),
      .ch_out       (ch_out),
      .valid_out    (valid_out),
      .sat_out      (sat_out),
      .coef_we_in   (coef_we_in),
      .coef_addr_in (coef_addr_in),
      .coef_data_in (coef_data_in),
      .hist_clr_in  (hist_clr_in)
   );

   biquad_bank #(.NUM_CH(3)) u_dut3 (
      .clk_in       (clk_in),
      .rst_n_in     (rst_n_in),
      .sample_in    (d3_sample),
      .ch_in        (d3_ch),
      .valid_in     (d3_valid),
      .ready_out    (d3_ready),
      .sample_out   (d3_sample_out),
      .ch_out       (d3_ch_out),
      .valid_out    (d3_valid_out),
      .sat_out      (d3_sat_out),
      .coef_we_in   (1'b0),
      .coef_addr_in (4'd0),
      .coef_data_in (32'sd0),
      .hist_clr_in  (1'b0)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference model: each section computes y = sum(b*x terms) - sum(a*y terms), clamped.
   longint m_coef [NUM_STAGES][5];
   longint m_x1 [2][NUM_STAGES];
   longint m_x2 [2][NUM_STAGES];
   longint m_y1 [2][NUM_STAGES];
   longint m_y2 [2][NUM_STAGES];

   function automatic void model_clear_hist();
      for (int c = 0; c < 2; c++) begin
         for (int s = 0; s < NUM_STAGES; s++) begin
            m_x1[c][s] = 0; m_x2[c][s] = 0; m_y1[c][s] = 0; m_y2[c][s] = 0;
         end
      end
   endfunction

   function automatic void model_reset();
      model_clear_hist();
      for (int s = 0; s < NUM_STAGES; s++) begin
         for (int k = 0; k < 5; k++) m_coef[s][k] = 0;
         m_coef[s][0] = longint'(1) << SHIFT;
      end
   endfunction

   function automatic void model_write(input int addr, input longint v);
      if (addr < 5 * NUM_STAGES) m_coef[addr / 5][addr % 5] = v;
   endfunction

   function automatic void model_step(input longint x_in, input int ch,
                                      output longint y, output bit sat);
      longint x, acc;
      x = x_in;
      sat = 1'b0;
      for (int s = 0; s < NUM_STAGES; s++) begin
         acc = ((m_coef[s][0] * x) >>> SHIFT)
             + ((m_coef[s][1] * m_x1[ch][s]) >>> SHIFT)
             + ((m_coef[s][2] * m_x2[ch][s]) >>> SHIFT)
             - ((m_coef[s][3] * m_y1[ch][s]) >>> SHIFT)
             - ((m_coef[s][4] * m_y2[ch][s]) >>> SHIFT);
         if (acc > MAXV) begin acc = MAXV; sat = 1'b1; end
         else if (acc < MINV) begin acc = MINV; sat = 1'b1; end
         m_x2[ch][s] = m_x1[ch][s];
         m_x1[ch][s] = x;
         m_y2[ch][s] = m_y1[ch][s];
         m_y1[ch][s] = acc;
         x = acc;
      end
      y = x;
   endfunction

   task automatic idle_inputs();
      sample_in = '0; ch_in = '0; valid_in = 1'b0;
      coef_we_in = 1'b0; coef_addr_in = '0; coef_data_in = '0; hist_clr_in = 1'b0;
      d3_sample = '0; d3_ch = '0; d3_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk_in);
      rst_n_in = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk_in);
      rst_n_in = 1'b1;
      @(negedge clk_in);
      model_reset();
   endtask

   task automatic wait_ready();
      int g;
      g = 0;
      while (!ready_out && g < 50) begin
         @(negedge clk_in);
         g++;
      end
      if (!ready_out) chk("ready_wait", ready_out, 1);
   endtask

   task automatic write_coef(input int addr, input int val);
      wait_ready();
      coef_we_in = 1'b1; coef_addr_in = 4'(addr); coef_data_in = val;
      @(negedge clk_in);
      coef_we_in = 1'b0;
      model_write(addr, longint'(val));
   endtask

   task automatic send(input int x, input int ch, output longint y, output longint ch_o,
                       output logic sat, output int lat);
      wait_ready();
      sample_in = x; ch_in = 1'(ch); valid_in = 1'b1;
      @(negedge clk_in);
      valid_in = 1'b0;
      lat = 1;
      while (!valid_out && lat < 40) begin
         @(negedge clk_in);
         lat++;
      end
      if (!valid_out) chk("valid_timeout", valid_out, 1);
      y = sample_out; ch_o = ch_out; sat = sat_out;
   endtask

   task automatic send_model(input int x, input int ch, input string name);
      longint y, ch_o, ey;
      logic sat;
      bit esat;
      int lat;
      send(x, ch, y, ch_o, sat, lat);
      model_step(longint'(x), ch, ey, esat);
      chk({name, "_y"}, y, ey);
      chk({name, "_ch"}, ch_o, ch);
      chk({name, "_sat"}, sat, esat);
   endtask

   typedef struct {
      int setup;
      int x;
      int ch;
      int exp_y;
      bit exp_sat;
   } vec_t;

   vec_t vecs [12];

   initial begin
      longint y, ch_o, ey;
      logic sat;
      bit esat;
      int lat, cnt;

      vecs[0]  = '{1, 4096, 0, 2048, 1'b0};
      vecs[1]  = '{0, 0, 0, 0, 1'b0};
      vecs[2]  = '{0, 0, 0, 0, 1'b0};
      vecs[3]  = '{2, 1024, 0, 1024, 1'b0};
      vecs[4]  = '{0, 0, 1, 0, 1'b0};
      vecs[5]  = '{0, 0, 0, 512, 1'b0};
      vecs[6]  = '{0, 0, 1, 0, 1'b0};
      vecs[7]  = '{0, 0, 0, 256, 1'b0};
      vecs[8]  = '{0, 0, 1, 0, 1'b0};
      vecs[9]  = '{0, 0, 0, 128, 1'b0};
      vecs[10] = '{3, 1073741824, 0, 2147483647, 1'b1};
      vecs[11] = '{0, -1073741824, 0, int'(32'h8000_0000), 1'b1};

      rst_n_in = 1'b0;
      idle_inputs();
      model_reset();
      @(negedge clk_in);
      chk("rst_ready", ready_out, 1);
      chk("rst_valid", valid_out, 0);
      chk("rst_sample", sample_out, 0);
      chk("rst_ch", ch_out, 0);
      chk("rst_sat", sat_out, 0);
      @(negedge clk_in);
      rst_n_in = 1'b1;
      @(negedge clk_in);

      // Passthrough after reset, including accept-to-strobe latency.
      send(1000, 0, y, ch_o, sat, lat);
      model_step(1000, 0, ey, esat);
      chk("pass_y", y, 1000);
      chk("pass_ch", ch_o, 0);
      chk("pass_sat", sat, 0);
      chk("pass_latency", lat, 13);

      // Directed vectors: gain, recursion with channel interleave, saturation.
      foreach (vecs[i]) begin
         case (vecs[i].setup)
            1: begin do_reset(); write_coef(0, 524288); end
            2: begin do_reset(); write_coef(3, -524288); end
            3: begin do_reset(); write_coef(0, 4 << 20); end
            default: ;
         endcase
         send(vecs[i].x, vecs[i].ch, y, ch_o, sat, lat);
         model_step(longint'(vecs[i].x), vecs[i].ch, ey, esat);
         chk($sformatf("vec%0d_y", i), y, vecs[i].exp_y);
         chk($sformatf("vec%0d_ch", i), ch_o, vecs[i].ch);
         chk($sformatf("vec%0d_sat", i), sat, vecs[i].exp_sat);
      end

      // Coefficient write while the MAC is busy must be ignored.
      do_reset();
      wait_ready();
      sample_in = 3333; ch_in = 1'b1; valid_in = 1'b1;
      @(negedge clk_in);
      valid_in = 1'b0;
      coef_we_in = 1'b1; coef_addr_in = 4'd0; coef_data_in = 32'sd0;
      @(negedge clk_in);
      coef_we_in = 1'b0;
      lat = 2;
      while (!valid_out && lat < 40) begin
         @(negedge clk_in);
         lat++;
      end
      chk("busy_wr_valid", valid_out, 1);
      chk("busy_wr_y", sample_out, 3333);
      chk("busy_wr_latency", lat, 13);
      model_step(3333, 1, ey, esat);
      send_model(77, 1, "busy_wr_after");

      // Reset in the middle of a sample aborts it and restores defaults.
      do_reset();
      send_model(700, 0, "pre_abort");
      wait_ready();
      sample_in = 5000; ch_in = 1'b0; valid_in = 1'b1;
      @(negedge clk_in);
      valid_in = 1'b0;
      repeat (4) @(negedge clk_in);
      rst_n_in = 1'b0;
      repeat (2) @(negedge clk_in);
      rst_n_in = 1'b1;
      cnt = 0;
      repeat (20) begin
         @(negedge clk_in);
         if (valid_out) cnt++;
      end
      chk("abort_no_valid", cnt, 0);
      chk("abort_ready", ready_out, 1);
      model_reset();
      write_coef(3, -524288);
      send(1024, 0, y, ch_o, sat, lat);
      model_step(1024, 0, ey, esat);
      chk("abort_hist_y0", y, 1024);
      send(0, 0, y, ch_o, sat, lat);
      model_step(0, 0, ey, esat);
      chk("abort_hist_y1", y, 512);

      // History clear wins over a simultaneous sample.
      wait_ready();
      hist_clr_in = 1'b1; sample_in = 999; ch_in = 1'b0; valid_in = 1'b1;
      #1;
      chk("clr_ready_low", ready_out, 0);
      @(negedge clk_in);
      hist_clr_in = 1'b0; valid_in = 1'b0;
      cnt = 0;
      repeat (20) begin
         @(negedge clk_in);
         if (valid_out) cnt++;
      end
      chk("clr_no_valid", cnt, 0);
      model_clear_hist();
      send(1024, 0, y, ch_o, sat, lat);
      model_step(1024, 0, ey, esat);
      chk("clr_y0", y, 1024);
      send(0, 0, y, ch_o, sat, lat);
      model_step(0, 0, ey, esat);
      chk("clr_y1", y, 512);

      // Randomized coefficients and samples against the reference model.
      do_reset();
      for (int s = 0; s < int'(NUM_STAGES); s++) begin
         write_coef(s * 5 + 0, int'($urandom_range(0, 2097152)) - 1048576);
         write_coef(s * 5 + 1, int'($urandom_range(0, 2097152)) - 1048576);
         write_coef(s * 5 + 2, int'($urandom_range(0, 2097152)) - 1048576);
         write_coef(s * 5 + 3, int'($urandom_range(0, 1048576)) - 524288);
         write_coef(s * 5 + 4, int'($urandom_range(0, 524288)) - 262144);
      end
      for (int i = 0; i < 40; i++) begin
         int x;
         if ($urandom_range(0, 3) == 0) x = int'($urandom());
         else x = int'($urandom_range(0, 131072)) - 65536;
         send_model(x, int'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
      end

      // Out-of-range channel on a three-channel instance is dropped.
      @(negedge clk_in);
      chk("d3_ready_idle", d3_ready, 1);
      d3_sample = 5; d3_ch = 2'd3; d3_valid = 1'b1;
      @(negedge clk_in);
      d3_valid = 1'b0;
      lat = 1;
      while (!d3_ready && lat < 2) begin
         @(negedge clk_in);
         lat++;
      end
      chk("d3_ready_back", d3_ready, 1);
      cnt = 0;
      repeat (20) begin
         if (d3_valid_out) cnt++;
         @(negedge clk_in);
      end
      chk("d3_drop_no_valid", cnt, 0);
      d3_sample = 1234; d3_ch = 2'd2; d3_valid = 1'b1;
      @(negedge clk_in);
      d3_valid = 1'b0;
      lat = 1;
      while (!d3_valid_out && lat < 40) begin
         @(negedge clk_in);
         lat++;
      end
      chk("d3_valid", d3_valid_out, 1);
      chk("d3_y", d3_sample_out, 1234);
      chk("d3_ch", d3_ch_out, 2);
      chk("d3_latency", lat, 13);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
